// File: rtl/motion_integrator.sv
// motion_integrator: valid/ready stage that accumulates signed 26-bit motion
// deltas into a registered position using a padder26 adder instance.
// Optional feature macro: INTEG_SATURATE_EN. When defined, a signed overflow
// clamps the position to the most positive or most negative value instead of
// wrapping. out_ovf is set on overflow in both builds.
//
// Output FSM states:
//   state | meaning
//   EMPTY | no unconsumed result; out_valid=0
//   FULL  | out_pos/out_ovf/out_count hold a result waiting for out_ready

module padder26 (
    input  logic [25:0] A,
    input  logic [25:0] B,
    input  logic        Cin,
    output logic [25:0] S,
    output logic        Cout
);

    // Plain ripple-style add; synthesis picks the carry structure.
    assign {Cout, S} = {1'b0, A} + {1'b0, B} + {26'b0, Cin};

endmodule

module motion_integrator #(
    parameter int W     = 26,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_delta,
    input  logic             in_load,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_pos,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);

    // The adder is hard-wired to 26 bits, so any other width cannot build.
    generate
        if (W != 26) begin : g_bad_width
            $error("motion_integrator: W must be 26 to match padder26");
        end
    endgenerate

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     pos_q, pos_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic [W-1:0]     add_sum;
    logic             add_cout_unused;
    logic             add_ovf;

    assign in_ready  = (state_q == EMPTY) | out_ready;
    assign accept    = in_valid & in_ready;

    assign out_valid = (state_q == FULL);
    assign out_pos   = pos_q;
    assign out_ovf   = ovf_q;
    assign out_count = cnt_q;

    padder26 u_add (
        .A    (pos_q),
        .B    (in_delta),
        .Cin  (1'b0),
        .S    (add_sum),
        .Cout (add_cout_unused)
    );

    // Signed overflow: operands agree in sign but the sum's sign differs.
    // The adder carry-out says nothing about signed overflow and is dropped.
    assign add_ovf = (pos_q[W-1] == in_delta[W-1]) & (add_sum[W-1] != pos_q[W-1]);

    // Output handshake FSM: next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (accept) state_d = FULL;
            end
            FULL: begin
                if (out_ready && !accept) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    // Datapath next values: registers move only on an accepted beat.
    always_comb begin
        pos_d = pos_q;
        ovf_d = ovf_q;
        cnt_d = cnt_q;
        if (accept) begin
            if (in_load) begin
                pos_d = in_delta;
                ovf_d = 1'b0;
                cnt_d = '0;
            end else begin
                pos_d = add_sum;
`ifdef INTEG_SATURATE_EN
                if (add_ovf) begin
                    pos_d = pos_q[W-1] ? {1'b1, {(W-1){1'b0}}}
                                       : {1'b0, {(W-1){1'b1}}};
                end
`endif
                if (add_ovf) ovf_d = 1'b1;
                if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State and datapath registers; reset wins over any beat in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            pos_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_motion_integrator.sv
// Self-checking bench for motion_integrator: a reference model pushes expected
// results to a scoreboard on every accepted beat; the DUT output is compared
// against the scoreboard head each cycle.
`timescale 1ns/1ps

module tb_motion_integrator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [25:0] in_delta;
    logic        in_load;
    logic        out_valid;
    logic        out_ready;
    logic [25:0] out_pos;
    logic        out_ovf;
    logic [15:0] out_count;

    always #5 clk = ~clk;

    motion_integrator #(.W(26), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_delta  (in_delta),
        .in_load   (in_load),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pos   (out_pos),
        .out_ovf   (out_ovf),
        .out_count (out_count)
    );

    typedef struct packed {
        logic [25:0] pos;
        logic        ovf;
        logic [15:0] cnt;
    } res_t;

    res_t        sb[$];
    logic [25:0] m_pos;
    logic        m_ovf;
    logic [15:0] m_cnt;
    int          checks = 0;
    int          errors = 0;

    // One clock cycle: drive inputs, check in_ready, update the model,
    // then after the edge compare outputs against the scoreboard head.
    task automatic step(input logic r, input logic v, input logic ld,
                        input logic [25:0] d, input logic ordy);
        logic        exp_ready;
        logic        acc;
        logic [25:0] sum;
        logic        o;
        res_t        exp;
        rst       = r;
        in_valid  = v;
        in_load   = ld;
        in_delta  = d;
        out_ready = ordy;
        #1;
        exp_ready = (sb.size() == 0) || ordy;
        checks++;
        if (in_ready !== exp_ready) begin
            errors++;
            $display("FAIL in_ready got %b expected %b at %0t", in_ready, exp_ready, $time);
        end
        if (r) begin
            sb.delete();
            m_pos = '0;
            m_ovf = 1'b0;
            m_cnt = '0;
        end else begin
            acc = v & exp_ready;
            if (sb.size() != 0 && ordy) void'(sb.pop_front());
            if (acc) begin
                if (ld) begin
                    m_pos = d;
                    m_ovf = 1'b0;
                    m_cnt = '0;
                end else begin
                    sum = m_pos + d;
                    o   = (m_pos[25] == d[25]) && (sum[25] != m_pos[25]);
`ifdef INTEG_SATURATE_EN
                    if (o) sum = m_pos[25] ? 26'h2000000 : 26'h1FFFFFF;
`endif
                    m_pos = sum;
                    if (o) m_ovf = 1'b1;
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                end
                sb.push_back('{pos: m_pos, ovf: m_ovf, cnt: m_cnt});
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() == 0) begin
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL out_valid got %b expected 0 at %0t", out_valid, $time);
            end
        end else begin
            exp = sb[0];
            if (out_valid !== 1'b1 || out_pos !== exp.pos || out_ovf !== exp.ovf ||
                out_count !== exp.cnt) begin
                errors++;
                $display("FAIL result got v=%b pos=%h ovf=%b cnt=%0d expected v=1 pos=%h ovf=%b cnt=%0d at %0t",
                         out_valid, out_pos, out_ovf, out_count, exp.pos, exp.ovf, exp.cnt, $time);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_load = 1'b0; in_delta = 26'd9; out_ready = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 1'b1, 1'b0, 26'd9, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || out_pos !== 26'd0 || out_count !== 16'd0 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got v=%b pos=%h cnt=%0d ovf=%b expected all zero",
                     out_valid, out_pos, out_count, out_ovf);
        end
        step(1'b0, 1'b0, 1'b0, 26'd0, 1'b1);
    endtask

    task automatic test_stream();
        logic [25:0] dl [4];
        logic [25:0] ep [4];
        dl = '{26'd100, 26'd5, 26'd5, -26'sd20};
        ep = '{26'd100, 26'd105, 26'd110, 26'd90};
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, (i == 0), dl[i], 1'b1);
            checks++;
            if (out_pos !== ep[i] || out_count !== 16'(i) || out_ovf !== 1'b0) begin
                errors++;
                $display("FAIL stream[%0d] got pos=%0d cnt=%0d ovf=%b expected pos=%0d cnt=%0d ovf=0",
                         i, out_pos, out_count, out_ovf, ep[i], i);
            end
        end
        step(1'b0, 1'b0, 1'b0, 26'd0, 1'b1);
    endtask

    task automatic test_backpressure();
        step(1'b0, 1'b1, 1'b1, 26'd50, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 26'd3, 1'b0);
            checks++;
            if (in_ready !== 1'b0 || out_pos !== 26'd50) begin
                errors++;
                $display("FAIL backpressure[%0d] got ready=%b pos=%0d expected ready=0 pos=50",
                         i, in_ready, out_pos);
            end
        end
        step(1'b0, 1'b1, 1'b0, 26'd3, 1'b1);
        checks++;
        if (out_pos !== 26'd53 || out_count !== 16'd1) begin
            errors++;
            $display("FAIL bp_release got pos=%0d cnt=%0d expected pos=53 cnt=1", out_pos, out_count);
        end
        step(1'b0, 1'b0, 1'b0, 26'd0, 1'b1);
    endtask

    task automatic test_overflow();
        logic [25:0] want;
`ifdef INTEG_SATURATE_EN
        want = 26'h1FFFFFF;
`else
        want = 26'h2000010;
`endif
        step(1'b0, 1'b1, 1'b1, 26'h1FFFFF0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 26'h0000020, 1'b1);
        checks++;
        if (out_ovf !== 1'b1 || out_pos !== want) begin
            errors++;
            $display("FAIL pos_overflow got pos=%h ovf=%b expected pos=%h ovf=1", out_pos, out_ovf, want);
        end
        step(1'b0, 1'b1, 1'b0, 26'd1, 1'b1);
        checks++;
        if (out_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got %b expected 1", out_ovf);
        end
        step(1'b0, 1'b1, 1'b1, 26'd0, 1'b1);
        checks++;
        if (out_ovf !== 1'b0 || out_count !== 16'd0) begin
            errors++;
            $display("FAIL ovf_clear got ovf=%b cnt=%0d expected ovf=0 cnt=0", out_ovf, out_count);
        end
    endtask

    task automatic test_neg_overflow();
        logic [25:0] want;
`ifdef INTEG_SATURATE_EN
        want = 26'h2000000;
`else
        want = 26'h1FFFFFF;
`endif
        step(1'b0, 1'b1, 1'b1, 26'h2000000, 1'b1);
        step(1'b0, 1'b1, 1'b0, 26'h3FFFFFF, 1'b1);
        checks++;
        if (out_ovf !== 1'b1 || out_pos !== want) begin
            errors++;
            $display("FAIL neg_overflow got pos=%h ovf=%b expected pos=%h ovf=1", out_pos, out_ovf, want);
        end
        step(1'b0, 1'b0, 1'b0, 26'd0, 1'b1);
    endtask

    task automatic test_mid_reset();
        step(1'b0, 1'b1, 1'b1, 26'd1234, 1'b0);
        step(1'b1, 1'b1, 1'b0, 26'd55, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || out_pos !== 26'd0) begin
            errors++;
            $display("FAIL mid_reset got v=%b pos=%0d expected v=0 pos=0", out_valid, out_pos);
        end
        step(1'b0, 1'b1, 1'b0, 26'd7, 1'b1);
        checks++;
        if (out_pos !== 26'd7 || out_count !== 16'd1) begin
            errors++;
            $display("FAIL after_reset got pos=%0d cnt=%0d expected pos=7 cnt=1", out_pos, out_count);
        end
    endtask

    task automatic test_count_saturation();
        step(1'b0, 1'b1, 1'b1, 26'd0, 1'b1);
        for (int i = 0; i < 65536; i++) step(1'b0, 1'b1, 1'b0, 26'd0, 1'b1);
        checks++;
        if (out_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL count_sat got %0d expected 65535", out_count);
        end
        step(1'b0, 1'b0, 1'b0, 26'd0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) == 0) ? 26'($urandom) : 26'($urandom_range(0, 40)) - 26'd20,
                 1'($urandom_range(0, 2) != 0));
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_overflow();
        test_neg_overflow();
        test_mid_reset();
        test_random();
        test_count_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
